// File: rtl/tower_pixel_queue.sv
// ---------------------------------------------------------------------------
// tower_pixel_queue
//
// Buffers the muxed tower pixel stream in a small FIFO and drains it to the
// VGA adapter write port at one pixel per cycle. It also owns a full-screen
// clear sweep. The sweep pre-empts the drain and flushes the pixels that are
// already queued.
//
// Optional feature macro: TOWER_QUEUE_BOUNDS_CHECK_EN
//   defined   : pushes with x >= X_MAX or y >= Y_MAX are discarded, and
//               dropped_count counts them (it saturates at 255).
//   undefined : all pushes are stored, and dropped_count is tied to 0.
//
// Ports
//   clk           in   single clock
//   resetn        in   asynchronous reset, active HIGH (legacy name)
//   in_wren       in   pixel write request
//   in_coord      in   {x[14:7], y[6:0]}
//   in_colour     in   9-bit colour
//   in_ready      out  FIFO not full
//   clear_req     in   single-cycle clear request
//   clear_busy    out  clear sweep in progress
//   vga_x/y       out  registered VGA coordinate
//   vga_colour    out  registered VGA colour
//   vga_plot      out  registered VGA write enable
//   fifo_level    out  FIFO occupancy
//   dropped_count out  discarded out-of-bounds pushes
// ---------------------------------------------------------------------------
module tower_pixel_queue #(
    parameter int         DEPTH     = 16,
    parameter logic [8:0] BG_COLOUR = 9'h000,
    parameter int         X_MAX     = 160,
    parameter int         Y_MAX     = 120
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_wren,
    input  logic [14:0]              in_coord,
    input  logic [8:0]               in_colour,
    output logic                     in_ready,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [8:0]               vga_colour,
    output logic                     vga_plot,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               dropped_count
);

    localparam int         AW         = $clog2(DEPTH);
    localparam int         LW         = AW + 1;
    localparam logic [AW:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [7:0] X_LAST     = 8'(X_MAX - 1);
    localparam logic [6:0] Y_LAST     = 7'(Y_MAX - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [7:0]      xc_q, xc_d;
    logic [6:0]      yc_q, yc_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic [8:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;

    // Each entry holds {coord, colour}.
    logic [23:0]     mem [DEPTH];
    logic [23:0]     rd_data;

    logic            push;
    logic            store;
    logic            pop;
    logic            flush;

    assign in_ready = (level_q != FULL_LEVEL);
    assign push     = in_wren && in_ready;
    assign rd_data  = mem[rd_ptr_q];

`ifdef TOWER_QUEUE_BOUNDS_CHECK_EN
    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    logic       in_bounds;
    logic [7:0] dropped_q, dropped_d;

    assign in_bounds = ({1'b0, in_coord[14:7]} < X_LIM) &&
                       ({1'b0, in_coord[6:0]}  < Y_LIM);
    assign store     = push && in_bounds;

    always_comb begin
        dropped_d = dropped_q;
        if (push && !in_bounds && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            dropped_q <= 8'd0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped_count = dropped_q;
`else
    assign store         = push;
    assign dropped_count = 8'd0;
`endif

    // The storage array has no reset. Only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr_q] <= {in_coord, in_colour};
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        xc_d         = xc_q;
        yc_d         = yc_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    // Queued pixels would be erased by the sweep, so drop them.
                    // No pop happens on this edge. A push on the same edge
                    // survives the flush.
                    flush    = 1'b1;
                    state_d  = S_CLEAR;
                    rd_ptr_d = wr_ptr_q;
                    xc_d     = 8'd0;
                    yc_d     = 7'd0;
                end else if (level_q != '0) begin
                    pop          = 1'b1;
                    rd_ptr_d     = rd_ptr_q + 1'b1;
                    vga_plot_d   = 1'b1;
                    vga_x_d      = rd_data[23:16];
                    vga_y_d      = rd_data[15:9];
                    vga_colour_d = rd_data[8:0];
                end
            end
            S_CLEAR: begin
                vga_plot_d   = 1'b1;
                vga_x_d      = xc_q;
                vga_y_d      = yc_q;
                vga_colour_d = BG_COLOUR;
                if (xc_q == X_LAST) begin
                    xc_d = 8'd0;
                    if (yc_q == Y_LAST) begin
                        yc_d    = 7'd0;
                        state_d = S_IDLE;
                    end else begin
                        yc_d = yc_q + 7'd1;
                    end
                end else begin
                    xc_d = xc_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (flush) begin
            level_d = {{AW{1'b0}}, store};
        end else if (pop && !store) begin
            level_d = level_q - 1'b1;
        end else if (store && !pop) begin
            level_d = level_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q      <= S_IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            xc_q         <= 8'd0;
            yc_q         <= 7'd0;
            vga_x_q      <= 8'd0;
            vga_y_q      <= 7'd0;
            vga_colour_q <= 9'd0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            xc_q         <= xc_d;
            yc_q         <= yc_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign clear_busy = (state_q == S_CLEAR);
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_tower_pixel_queue.sv
// ---------------------------------------------------------------------------
// Testbench for tower_pixel_queue.
//
// A queue-based reference model runs on every clock edge and pushes each
// expected plot into a scoreboard. A monitor on the falling edge pops the
// scoreboard and compares it with the DUT outputs. The monitor also compares
// the occupancy and status outputs against the model on the same edge.
// ---------------------------------------------------------------------------
module tb_tower_pixel_queue;

    localparam int         DEPTH = 16;
    localparam int         X_MAX = 160;
    localparam int         Y_MAX = 120;
    localparam logic [8:0] BG    = 9'h155;
    localparam int         NPIX  = X_MAX * Y_MAX;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
    } pix_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        in_wren = 1'b0;
    logic [14:0] in_coord = '0;
    logic [8:0]  in_colour = '0;
    logic        in_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot;
    logic [4:0]  fifo_level;
    logic [7:0]  dropped_count;

    tower_pixel_queue #(
        .DEPTH(DEPTH), .BG_COLOUR(BG), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk), .resetn(resetn), .in_wren(in_wren), .in_coord(in_coord),
        .in_colour(in_colour), .in_ready(in_ready), .clear_req(clear_req),
        .clear_busy(clear_busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot), .fifo_level(fifo_level),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 60)
                $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    pix_t mq[$];      // modelled FIFO contents
    pix_t exp_q[$];   // scoreboard of expected plots
    bit   m_clear = 0;
    int   m_n     = 0;
    int   m_drop  = 0;
    bit   exp_plot = 0;

    always @(posedge clk or posedge resetn) begin
        bit   push;
        bit   store;
        pix_t p;
        if (resetn) begin
            mq.delete();
            exp_q.delete();
            m_clear  = 0;
            m_n      = 0;
            m_drop   = 0;
            exp_plot = 0;
        end else begin
            push  = in_wren && (mq.size() != DEPTH);
            store = push;
`ifdef TOWER_QUEUE_BOUNDS_CHECK_EN
            if (push && ((int'(in_coord[14:7]) >= X_MAX) || (int'(in_coord[6:0]) >= Y_MAX))) begin
                store = 0;
                if (m_drop < 255) m_drop++;
            end
`endif
            exp_plot = 0;
            if (!m_clear && clear_req) begin
                mq.delete();
                m_clear = 1;
                m_n     = 0;
            end else if (m_clear) begin
                p.x = 8'(m_n % X_MAX);
                p.y = 7'(m_n / X_MAX);
                p.c = BG;
                exp_q.push_back(p);
                exp_plot = 1;
                m_n++;
                if (m_n == NPIX) m_clear = 0;
            end else if (mq.size() > 0) begin
                p = mq.pop_front();
                exp_q.push_back(p);
                exp_plot = 1;
            end
            if (store) begin
                p.x = in_coord[14:7];
                p.y = in_coord[6:0];
                p.c = in_colour;
                mq.push_back(p);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        pix_t p;
        chk("plot", 32'(vga_plot), 32'(exp_plot));
        if (exp_plot) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                p = exp_q.pop_front();
                if (vga_plot)
                    chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(p));
            end
        end
        chk("level", 32'(fifo_level), 32'(mq.size()));
        chk("ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("busy", 32'(clear_busy), 32'(m_clear));
        chk("dropped", 32'(dropped_count), 32'(m_drop));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit w, input int x, input int y, input int c, input bit clr);
        @(posedge clk);
        #1;
        in_wren   = w;
        in_coord  = {8'(x), 7'(y)};
        in_colour = 9'(c);
        clear_req = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // 1. reset values
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_plot", 32'(vga_plot), 32'd0);
        chk("rst_busy", 32'(clear_busy), 32'd0);

        // 2. single write, one-cycle latency, one-cycle plot
        step(1, 10, 20, 9'h1C0, 0);
        step(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("single_plot", 32'(vga_plot), 32'd1);
        chk("single_pix", 32'({vga_x, vga_y, vga_colour}), {8'd0, 8'd10, 7'd20, 9'h1C0});
        @(posedge clk); #1;
        chk("single_plot_end", 32'(vga_plot), 32'd0);

        // 3. full FIFO during a clear, 17th write ignored
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) step(1, i + 1, i + 2, i * 7 + 1, 0);
        chk("full_level", 32'(fifo_level), 32'd16);
        chk("full_ready", 32'(in_ready), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("full_level_hold", 32'(fifo_level), 32'd16);
        idle(500);
        step(0, 0, 0, 0, 1);   // ignored while sweeping
        idle(NPIX);

        // 4. flush: 5 pushes, then push (3,4) together with a clear
        for (int i = 0; i < 5; i++) step(1, 50 + i, 60 + i, 9'h0F0 + i, 0);
        step(1, 3, 4, 9'h03F, 1);
        step(0, 0, 0, 0, 0);
        chk("flush_level", 32'(fifo_level), 32'd1);
        chk("flush_busy", 32'(clear_busy), 32'd1);
        idle(NPIX + 10);

        // 5. reset in the middle of a sweep
        step(0, 0, 0, 0, 1);
        idle(500);
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("midrst_plot", 32'(vga_plot), 32'd0);
        chk("midrst_busy", 32'(clear_busy), 32'd0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        idle(30);

        // 6. out-of-bounds push
        step(1, 200, 5, 9'h0AA, 0);
        idle(4);
`ifdef TOWER_QUEUE_BOUNDS_CHECK_EN
        chk("bounds_dropped", 32'(dropped_count), 32'd1);
`else
        chk("bounds_dropped", 32'(dropped_count), 32'd0);
`endif

        // Random traffic in idle, then random traffic through a sweep.
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 199), $urandom_range(0, 127),
                 $urandom_range(0, 511), 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < NPIX + 300; i++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 170), $urandom_range(0, 125),
                 $urandom_range(0, 511), $urandom_range(0, 999) == 0);
        idle(40);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tower_pixel_queue.md
# tower_pixel_queue

Downstream of the tower drawing stages: accepts the muxed tower pixel stream (`coord`, `colour`, `tower_wren`) and buffers it in a FIFO. Drains the FIFO to the VGA adapter write port at one pixel per cycle. Also owns a full-screen clear sweep that pre-empts the drain. Decouples the stage drawing FSMs from VGA write timing and gives the stage controller a single clear-and-redraw point.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 4.
- `BG_COLOUR`, 9'h000: colour written during a clear sweep.
- `X_MAX`, 160: screen width in pixels.
- `Y_MAX`, 120: screen height in pixels.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-high reset (the port name is kept for codebase consistency; polarity is high).
- `in_wren` in 1: pixel write request from the tower stages.
- `in_coord` in 15: {x[14:7], y[6:0]}.
- `in_colour` in 9: pixel colour, 3 bits per channel.
- `in_ready` out 1: FIFO not full.
- `clear_req` in 1: request a full-screen clear; single-cycle pulse.
- `clear_busy` out 1: clear sweep in progress.
- `vga_x` out 8: registered VGA x coordinate.
- `vga_y` out 7: registered VGA y coordinate.
- `vga_colour` out 9: registered VGA colour.
- `vga_plot` out 1: registered VGA write enable.
- `fifo_level` out log2(DEPTH)+1: current FIFO occupancy.
- `dropped_count` out 8: count of out-of-bounds writes discarded (see Configuration).

## Operation
- **Push:** occurs when `in_wren && in_ready`. If `in_wren` is high while `in_ready` is low, the write is ignored; upstream must hold it.
- **`in_ready`:** equals `fifo_level != DEPTH`. There is no full-bypass, so a push into a full FIFO never happens, even with a simultaneous pop.
- **FSM state IDLE:**
  - If the FIFO is non-empty, pop one entry per cycle into `vga_x/vga_y/vga_colour` and set `vga_plot=1`.
  - If the FIFO is empty, `vga_plot=0`; the x/y/colour outputs hold their last values.
- **IDLE -> CLEAR on `clear_req`:**
  - All entries already in the FIFO are flushed (they would be erased anyway).
  - A write pushed in the same cycle as `clear_req` is kept; it is the first surviving entry.
- **FSM state CLEAR:**
  - Counters xc (8b) and yc (7b) start at 0.
  - Each cycle emits (xc, yc, `BG_COLOUR`) with `vga_plot=1`.
  - xc increments first; when xc reaches X_MAX-1 it wraps to 0 and yc increments.
  - After emitting (X_MAX-1, Y_MAX-1), the FSM returns to IDLE.
  - Pushes continue during CLEAR and are drained after it.
  - `clear_req` during CLEAR is ignored; the sweep does not restart.
- **Flow:** push and pop in the same cycle leave `fifo_level` unchanged. Pointers wrap modulo DEPTH.
- **Reset (asynchronous):**
  - Outputs: `vga_*`=0, `vga_plot`=0, `clear_busy`=0, `in_ready`=1, `fifo_level`=0, `dropped_count`=0.
  - Internal: state IDLE, pointers 0.
  - Reset asserted mid-clear aborts the sweep; no further plots are issued.

## Timing
- **Push-to-plot latency:** `in_wren` sampled at edge k into an empty FIFO in IDLE -> popped at edge k+1 -> `vga_plot=1` with that pixel for the cycle after edge k+1.
- **Throughput:** 1 pixel/cycle sustained in IDLE.
- **Clear sequence:** `clear_req` sampled at edge k:
  - `clear_busy`=1 after edge k.
  - Pixel (0,0) is presented after edge k+1.
  - Pixel n is presented after edge k+1+n.
  - The last pixel, (159,119), is presented after edge k+19200; `clear_busy` falls at that same edge.
  - FIFO drain resumes at edge k+19201.
- **`vga_plot` during clear:** high continuously for exactly X_MAX*Y_MAX = 19200 cycles.
- **Flush:** takes effect at edge k; `fifo_level` after edge k is 1 if a push coincided with `clear_req`, else 0.

## Configuration
- **Macro `TOWER_QUEUE_BOUNDS_CHECK_EN`.**
- **Defined:**
  - A push with x >= X_MAX or y >= Y_MAX is not stored.
  - `dropped_count` increments, saturating at 255.
  - `in_ready` is unaffected.
- **Undefined:**
  - All pushes are stored unchanged.
  - `dropped_count` is tied to 0.

## Test plan
1. **Reset values:** assert reset, release -> `in_ready`=1, `fifo_level`=0, `vga_plot`=0, `clear_busy`=0.
2. **Single write:** push coord {8'd10, 7'd20}, colour 9'h1C0 -> one cycle later `vga_plot`=1, `vga_x`=10, `vga_y`=20, `vga_colour`=9'h1C0, for exactly one cycle.
3. **Full FIFO:** hold `clear_busy` via a clear, push 16 writes -> `in_ready`=0 and `fifo_level`=16. A 17th write is ignored. After the sweep, exactly 16 plots are issued, in order.
4. **Clear flush:** fill 5 entries in IDLE, pulse `clear_req` together with a push of (3,4) -> 19200 `BG_COLOUR` plots in raster order ending at (159,119), then exactly one plot at (3,4).
5. **Reset mid-clear:** reset at sweep cycle 500 -> `vga_plot`=0 immediately, `clear_busy`=0, no further plots.
6. **Bounds check (with `TOWER_QUEUE_BOUNDS_CHECK_EN`):** push x=200, y=5 -> no plot, `dropped_count`=1. The same push without the macro -> plot issued at x=200.
